// File: rtl/motor_sequencer.sv
// Motor speed sequencer: soft-start ramp, stall detection, timed escape turn and
// fault latch in front of the wheel PWM block.
module motor_sequencer #(
  parameter int unsigned RAMP_TICKS       = 25_000_000,
  parameter int unsigned STALL_CYCLES     = 50_000_000,
  parameter int unsigned TURN_CYCLES      = 100_000_000,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned RETRY_CLR_CYCLES = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] req_speed,
  input  logic       stall_detect,
  output logic [1:0] speed,
  output logic       isStuck,
  output logic [2:0] state,
  output logic [1:0] retry_cnt
);

  localparam int unsigned RW = $clog2(RAMP_TICKS + 1);
  localparam int unsigned SW = $clog2(STALL_CYCLES + 1);
  localparam int unsigned TW = $clog2(TURN_CYCLES + 1);
  localparam int unsigned CW = $clog2(RETRY_CLR_CYCLES + 1);

  localparam logic [1:0] SPD_SLOW = 2'b00;
  localparam logic [1:0] SPD_OFF  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_RAMP  = 3'b001,
    ST_RUN   = 3'b010,
    ST_STUCK = 3'b011,
    ST_FAULT = 3'b100
  } state_e;

  state_e        state_q;
  logic [1:0]    speed_q;
  logic          stuck_q;
  logic [1:0]    retry_q;
  logic [RW-1:0] ramp_q;
  logic [SW-1:0] stall_q;
  logic [TW-1:0] turn_q;
  logic [CW-1:0] clr_q;

  logic halt_c;
  logic stall_hit_c;
  logic retry_ok_c;

  // Stop request, stall terminal count and retry budget for this cycle
  always_comb begin
    halt_c      = stop || (req_speed == SPD_OFF);
    stall_hit_c = stall_detect && (stall_q == SW'(STALL_CYCLES - 1));
    retry_ok_c  = 32'(retry_q) < MAX_RETRY;
  end

  // Sequencer FSM with registered motor command and bookkeeping counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      speed_q <= SPD_OFF;
      stuck_q <= 1'b0;
      retry_q <= 2'd0;
      ramp_q  <= '0;
      stall_q <= '0;
      turn_q  <= '0;
      clr_q   <= '0;
    end else begin
      // Retry-clear window only runs while in RUN; RUN overrides below
      clr_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && !halt_c) begin
            state_q <= ST_RAMP;
            speed_q <= SPD_SLOW;
            ramp_q  <= '0;
            stall_q <= '0;
          end
        end

        ST_RAMP, ST_RUN: begin
          if (halt_c) begin
            state_q <= ST_IDLE;
            speed_q <= SPD_OFF;
            stuck_q <= 1'b0;
            retry_q <= 2'd0;
            ramp_q  <= '0;
            stall_q <= '0;
            turn_q  <= '0;
          end else if (stall_hit_c) begin
            stall_q <= '0;
            ramp_q  <= '0;
            turn_q  <= '0;
            if (retry_ok_c) begin
              state_q <= ST_STUCK;
              speed_q <= SPD_SLOW;
              stuck_q <= 1'b1;
              retry_q <= retry_q + 2'd1;
            end else begin
              state_q <= ST_FAULT;
              speed_q <= SPD_OFF;
            end
          end else begin
            stall_q <= stall_detect ? stall_q + SW'(1) : '0;
            if (state_q == ST_RAMP) begin
              // Down-steps and equal targets skip the ramp entirely
              if (req_speed <= speed_q) begin
                state_q <= ST_RUN;
                speed_q <= req_speed;
              end else if (ramp_q == RW'(RAMP_TICKS - 1)) begin
                ramp_q  <= '0;
                speed_q <= speed_q + 2'd1;
                if ((speed_q + 2'd1) == req_speed) begin
                  state_q <= ST_RUN;
                end
              end else begin
                ramp_q <= ramp_q + RW'(1);
              end
            end else begin
              if (!stall_detect) begin
                if (clr_q == CW'(RETRY_CLR_CYCLES - 1)) begin
                  retry_q <= 2'd0;
                  clr_q   <= '0;
                end else begin
                  clr_q <= clr_q + CW'(1);
                end
              end
              if (req_speed > speed_q) begin
                state_q <= ST_RAMP;
                ramp_q  <= '0;
              end else begin
                speed_q <= req_speed;
              end
            end
          end
        end

        ST_STUCK: begin
          if (halt_c) begin
            state_q <= ST_IDLE;
            speed_q <= SPD_OFF;
            stuck_q <= 1'b0;
            retry_q <= 2'd0;
            turn_q  <= '0;
          end else if (turn_q == TW'(TURN_CYCLES - 1)) begin
            state_q <= ST_RAMP;
            speed_q <= SPD_SLOW;
            stuck_q <= 1'b0;
            turn_q  <= '0;
            ramp_q  <= '0;
            stall_q <= '0;
          end else begin
            turn_q <= turn_q + TW'(1);
          end
        end

        ST_FAULT: begin
          if (stop) begin
            state_q <= ST_IDLE;
            speed_q <= SPD_OFF;
            stuck_q <= 1'b0;
            retry_q <= 2'd0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          speed_q <= SPD_OFF;
          stuck_q <= 1'b0;
          retry_q <= 2'd0;
        end
      endcase
    end
  end

  assign speed     = speed_q;
  assign isStuck   = stuck_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule
